delay_meas: RTL and testbench
=============================

DELAY_MEAS -- requirements
Module: delay_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the delay counter and result.
REQ-002 SHALL have parameter TIMEOUT, default 1000, maximum delay in cycles before timeout; legal range 1..2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: start of measurement, sampled high in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: end of measurement, sampled high in COUNT.
REQ-007 SHALL have port abort, input, 1 bit: synchronous cancel, return to IDLE.
REQ-008 SHALL have port ack, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have port busy, output, 1 bit: high in COUNT.
REQ-010 SHALL have port valid, output, 1 bit: high in DONE, result stable.
REQ-011 SHALL have port delay, output, CNT_W bits: measured delay in clk cycles.
REQ-012 SHALL have port timeout, output, 1 bit: result ended by timeout, qualified by valid.
REQ-013 SHALL have port stats_clr, input, 1 bit: synchronous clear of the min/max statistics.
REQ-014 SHALL have ports min_dly and max_dly, output, CNT_W bits each: statistics.

Function
REQ-015 SHALL implement the states IDLE, COUNT and DONE with a registered state.
REQ-016 In IDLE with start=1 at edge N: SHALL go to COUNT and set cnt=1.
REQ-017 In COUNT with stop=1 at edge N+k: SHALL go to DONE and latch delay=k (=cnt) and timeout=0.
- Minimum measurable delay is 1.
- Stop in the same cycle as start is ignored.
REQ-018 In COUNT with stop=0: SHALL increment cnt.
- When cnt==TIMEOUT and stop=0, SHALL go to DONE with delay=TIMEOUT and timeout=1.
- The counter never wraps.
REQ-019 If stop=1 and cnt==TIMEOUT in the same cycle: SHALL resolve as stop, giving delay=TIMEOUT and timeout=0.
REQ-020 In DONE: valid=1, delay and timeout held constant.
- ack=1 → IDLE at the next edge; valid falls in the same edge.
REQ-021 SHALL ignore start while in COUNT or DONE, including start coincident with ack in DONE.
REQ-022 abort=1 in COUNT or DONE: SHALL go to IDLE next edge, no result, delay/timeout/statistics unchanged.
- abort has priority over stop, timeout and ack.
REQ-023 busy SHALL equal (state==COUNT); valid SHALL equal (state==DONE); both registered-state decodes, no combinational path from inputs.
REQ-024 Outputs delay and timeout SHALL change only on entry to DONE.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, cnt=0, delay=0, timeout=0, busy=0, valid=0.
REQ-026 rst=0 SHALL force min_dly=all-ones and max_dly=0.
REQ-027 Reset mid-measurement SHALL discard the measurement.
- First start is accepted at the first edge after rst deasserts.

Configuration
REQ-028 With macro DELAY_MEAS_STATS_EN defined: on each entry to DONE with timeout=0:
- min_dly=min(min_dly,delay), max_dly=max(max_dly,delay), updated in the same edge as delay.
- Timeout results SHALL not update the statistics.
- stats_clr=1 SHALL restore the reset values (all-ones/0), with priority over a coincident update.
REQ-029 Without DELAY_MEAS_STATS_EN: min_dly and max_dly SHALL be constant 0, stats_clr ignored, and no statistics registers present.

Verification
REQ-030 start at edge 10, stop at edge 15 → valid at edge 15, delay=5, timeout=0; ack at edge 18 → valid=0 after edge 18.
REQ-031 TIMEOUT=8, start, no stop → valid after 8 cycles, delay=8, timeout=1; stop on 8th cycle instead → delay=8, timeout=0.
REQ-032 start and stop high together in IDLE, stop held → delay=1; start pulsed during COUNT and DONE → no restart, delay unaffected.
REQ-033 abort in COUNT at cnt=3 → IDLE, valid never rises; rst low mid-COUNT → all outputs 0 immediately, asynchronously.
REQ-034 STATS_EN, delays 7, 3, 12, then a timeout → min_dly=3, max_dly=12; stats_clr → all-ones/0.
REQ-035 Without STATS_EN, same sequence as REQ-034 → min_dly=max_dly=0.

Source files
------------

// File: rtl/delay_meas.sv
// Start/stop delay meter with timeout, consumer handshake and optional min/max statistics.
// Define DELAY_MEAS_STATS_EN to build the min_dly/max_dly statistics registers.
`timescale 1ns/1ps
module delay_meas #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic             ack,
  input  logic             stats_clr,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] delay,
  output logic             timeout,
  output logic [CNT_W-1:0] min_dly,
  output logic [CNT_W-1:0] max_dly
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             latch_en;
  logic             latch_tmo;

  // Counter holds at all-ones rather than wrapping; TIMEOUT normally stops it first.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch_en  = 1'b0;
    latch_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      COUNT: begin
        // abort beats stop, and stop beats a coincident timeout
        if (abort) begin
          state_nxt = IDLE;
        end else if (stop) begin
          state_nxt = DONE;
          latch_en  = 1'b1;
        end else if (cnt == TMO) begin
          state_nxt = DONE;
          latch_en  = 1'b1;
          latch_tmo = 1'b1;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      DONE: begin
        if (abort || ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      delay   <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch_en) begin
        delay   <= cnt;
        timeout <= latch_tmo;
      end
    end
  end

  assign busy  = (state == COUNT);
  assign valid = (state == DONE);

`ifdef DELAY_MEAS_STATS_EN
  logic stat_upd;
  assign stat_upd = latch_en && !latch_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_dly <= '1;
      max_dly <= '0;
    end else if (stats_clr) begin
      min_dly <= '1;
      max_dly <= '0;
    end else if (stat_upd) begin
      if (cnt < min_dly) min_dly <= cnt;
      if (cnt > max_dly) max_dly <= cnt;
    end
  end
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign min_dly = '0;
  assign max_dly = '0;
`endif

endmodule

// File: tb/tb_delay_meas.sv
// Bench for delay_meas: two instances (TIMEOUT 8 and 20) on shared inputs, table rows plus random transactions.
`timescale 1ns/1ps
module tb_delay_meas;
  localparam int W    = 8;
  localparam int ALL1 = 255;
`ifdef DELAY_MEAS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, stop, abort, ack, stats_clr;
  logic [1:0]   busy_w, valid_w, tmo_w;
  logic [W-1:0] dly_w [2];
  logic [W-1:0] min_w [2];
  logic [W-1:0] max_w [2];

  always #5 clk = ~clk;

  delay_meas #(.CNT_W(W), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort), .ack(ack),
    .stats_clr(stats_clr), .busy(busy_w[0]), .valid(valid_w[0]), .delay(dly_w[0]),
    .timeout(tmo_w[0]), .min_dly(min_w[0]), .max_dly(max_w[0]));

  delay_meas #(.CNT_W(W), .TIMEOUT(20)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort), .ack(ack),
    .stats_clr(stats_clr), .busy(busy_w[1]), .valid(valid_w[1]), .delay(dly_w[1]),
    .timeout(tmo_w[1]), .min_dly(min_w[1]), .max_dly(max_w[1]));

  int nchk = 0;
  int nerr = 0;

  // Transaction-level expectations per instance
  int m_dly [2];
  int m_min [2];
  int m_max [2];
  bit m_busy [2];
  bit m_valid [2];
  bit m_tmo [2];

  function automatic int tmo_of(input int i);
    return (i == 0) ? 8 : 20;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dly[i] = 0; m_tmo[i] = 0; m_busy[i] = 0; m_valid[i] = 0;
      m_min[i] = ALL1; m_max[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.busy%0d", tag, i),  32'(busy_w[i]),  32'(m_busy[i]));
      chk($sformatf("%s.valid%0d", tag, i), 32'(valid_w[i]), 32'(m_valid[i]));
      chk($sformatf("%s.delay%0d", tag, i), 32'(dly_w[i]),   32'(m_dly[i]));
      chk($sformatf("%s.tmo%0d", tag, i),   32'(tmo_w[i]),   32'(m_tmo[i]));
      chk($sformatf("%s.min%0d", tag, i),   32'(min_w[i]),   STATS ? 32'(m_min[i]) : 32'd0);
      chk($sformatf("%s.max%0d", tag, i),   32'(max_w[i]),   STATS ? 32'(m_max[i]) : 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin m_min[i] = ALL1; m_max[i] = 0; end
    check_all("clr");
  endtask

  // One measurement from IDLE: stop k cycles after start (if do_stop), optional abort,
  // optional stats_clr on the last cycle. Leaves the DUTs in DONE unless aborted.
  task automatic run_meas(input int k, input bit do_stop, input int abort_in,
                          input bit clr_at_end, output bit aborted);
    int e [2];
    bit t [2];
    int L, ab_at;
    bit ab, clr_now;
    for (int i = 0; i < 2; i++) begin
      if (do_stop && k <= tmo_of(i)) begin e[i] = k; t[i] = 1'b0; end
      else begin e[i] = tmo_of(i); t[i] = 1'b1; end
    end
    ab_at = abort_in;
    if (ab_at > 0 && ab_at > ((e[0] < e[1]) ? e[0] : e[1])) ab_at = (e[0] < e[1]) ? e[0] : e[1];
    L = (ab_at > 0) ? ab_at : ((e[0] > e[1]) ? e[0] : e[1]);
    aborted = (ab_at > 0);

    start = 1'b1;
    stop  = (do_stop && k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i < 2; i++) begin m_busy[i] = 1'b1; m_valid[i] = 1'b0; end
    check_all("start");

    for (int c = 1; c <= L; c++) begin
      start     = 1'($urandom_range(0, 1));
      stop      = (do_stop && c == k);
      ab        = (ab_at > 0 && c == ab_at);
      abort     = ab;
      clr_now   = clr_at_end && (c == L);
      stats_clr = clr_now;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (ab) begin
          m_busy[i] = 1'b0; m_valid[i] = 1'b0;
        end else if (c == e[i]) begin
          m_busy[i] = 1'b0; m_valid[i] = 1'b1; m_dly[i] = e[i]; m_tmo[i] = t[i];
        end
        if (clr_now) begin
          m_min[i] = ALL1; m_max[i] = 0;
        end else if (!ab && c == e[i] && !t[i]) begin
          if (e[i] < m_min[i]) m_min[i] = e[i];
          if (e[i] > m_max[i]) m_max[i] = e[i];
        end
      end
      check_all($sformatf("cnt%0d", c));
    end
    start = 1'b0; stop = 1'b0; abort = 1'b0; stats_clr = 1'b0;
    if (aborted) begin
      tick();
      check_all("post_abort");
    end
  endtask

  // Hold DONE with start/stop noise, then ack (with a possibly coincident start).
  task automatic finish_meas(input int hold);
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1));
      stop  = 1'($urandom_range(0, 1));
      tick();
      check_all("hold");
    end
    ack   = 1'b1;
    start = 1'($urandom_range(0, 1));
    stop  = 1'b0;
    tick();
    ack = 1'b0; start = 1'b0;
    for (int i = 0; i < 2; i++) begin m_busy[i] = 1'b0; m_valid[i] = 1'b0; end
    check_all("ack");
    tick();
    check_all("idle");
  endtask

  typedef struct {
    int k;
    bit do_stop;
    int abort_at;
    int exp_dly;
    bit exp_tmo;
    bit exp_valid;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ab;
    tbl[0] = '{k: 5,  do_stop: 1'b1, abort_at: 0, exp_dly: 5, exp_tmo: 1'b0, exp_valid: 1'b1};
    tbl[1] = '{k: 8,  do_stop: 1'b1, abort_at: 0, exp_dly: 8, exp_tmo: 1'b0, exp_valid: 1'b1};
    tbl[2] = '{k: 0,  do_stop: 1'b0, abort_at: 0, exp_dly: 8, exp_tmo: 1'b1, exp_valid: 1'b1};
    tbl[3] = '{k: 1,  do_stop: 1'b1, abort_at: 0, exp_dly: 1, exp_tmo: 1'b0, exp_valid: 1'b1};
    tbl[4] = '{k: 10, do_stop: 1'b1, abort_at: 3, exp_dly: 1, exp_tmo: 1'b0, exp_valid: 1'b0};
    tbl[5] = '{k: 9,  do_stop: 1'b1, abort_at: 0, exp_dly: 8, exp_tmo: 1'b1, exp_valid: 1'b1};

    rst = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; ack = 1'b0; stats_clr = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    tick();
    check_all("after_reset");

    for (int v = 0; v < 6; v++) begin
      run_meas(tbl[v].k, tbl[v].do_stop, tbl[v].abort_at, 1'b0, ab);
      chk($sformatf("tbl%0d.delay", v), 32'(dly_w[0]),   32'(tbl[v].exp_dly));
      chk($sformatf("tbl%0d.tmo", v),   32'(tmo_w[0]),   32'(tbl[v].exp_tmo));
      chk($sformatf("tbl%0d.valid", v), 32'(valid_w[0]), 32'(tbl[v].exp_valid));
      if (!ab) finish_meas(2);
    end

    // Statistics: delays 7, 3, 12, then a timeout
    clear_stats();
    run_meas(7, 1'b1, 0, 1'b0, ab);  finish_meas(1);
    run_meas(3, 1'b1, 0, 1'b0, ab);  finish_meas(1);
    run_meas(12, 1'b1, 0, 1'b0, ab); finish_meas(1);
    run_meas(0, 1'b0, 0, 1'b0, ab);  finish_meas(1);
    chk("stats.min20", 32'(min_w[1]), STATS ? 32'd3  : 32'd0);
    chk("stats.max20", 32'(max_w[1]), STATS ? 32'd12 : 32'd0);
    chk("stats.min8",  32'(min_w[0]), STATS ? 32'd3  : 32'd0);
    chk("stats.max8",  32'(max_w[0]), STATS ? 32'd7  : 32'd0);
    clear_stats();
    chk("stats.clr_min", 32'(min_w[1]), STATS ? 32'd255 : 32'd0);
    chk("stats.clr_max", 32'(max_w[1]), 32'd0);
    run_meas(4, 1'b1, 0, 1'b1, ab);
    chk("stats.clr_prio_min", 32'(min_w[0]), STATS ? 32'd255 : 32'd0);
    chk("stats.clr_prio_max", 32'(max_w[0]), 32'd0);
    chk("stats.clr_prio_dly", 32'(dly_w[0]), 32'd4);
    finish_meas(0);
    run_meas(6, 1'b1, 0, 1'b0, ab); finish_meas(0);

    // Asynchronous reset in the middle of a count
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) m_busy[i] = 1'b1;
    check_all("first_start");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 2; i++) m_busy[i] = 1'b0;
    check_all("abort_after_rst");

    for (int n = 0; n < 40; n++) begin
      int k, ab_at, hold;
      bit ds;
      k     = $urandom_range(1, 24);
      ds    = ($urandom_range(0, 3) != 0);
      ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0;
      hold  = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) clear_stats();
      run_meas(k, ds, ab_at, 1'b0, ab);
      if (!ab) finish_meas(hold);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
